// File: rtl/sarray_ld_sched.sv
// Load scheduler for the systolic-array operand path: issues one stride-addressed read burst
// per command under an outstanding-request credit limit and steers returned beats.
module sarray_ld_sched #(
    parameter int ADDR_WIDTH  = 64,
    parameter int LOAD_WIDTH  = 256,
    parameter int BEATS       = 64,
    parameter int CNT_WIDTH   = 6,
    parameter int STRIDE_LOG2 = 8,
    parameter int MAX_OUTST   = 8,
    parameter int OUTST_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_type_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic                  cmd_abuf_id_i,
    output logic                  ar_valid_o,
    input  logic                  ar_ready_i,
    output logic [ADDR_WIDTH-1:0] ar_addr_o,
    input  logic                  r_valid_i,
    output logic                  r_ready_o,
    input  logic [LOAD_WIDTH-1:0] r_data_i,
    output logic                  abuf_wr_valid_o,
    output logic                  abuf_wr_id_o,
    output logic [CNT_WIDTH-1:0]  abuf_wr_idx_o,
    output logic [LOAD_WIDTH-1:0] abuf_wr_data_o,
    output logic                  top_valid_o,
    input  logic                  top_ready_i,
    output logic [CNT_WIDTH-1:0]  top_cnt_o,
    output logic [LOAD_WIDTH-1:0] top_data_o,
    output logic                  busy_o,
    output logic                  done_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [CNT_WIDTH-1:0]   LAST_BEAT = CNT_WIDTH'(BEATS - 1);
    localparam logic [OUTST_WIDTH-1:0] OUTST_MAX = OUTST_WIDTH'(MAX_OUTST);

    state_t                  state;
    state_t                  state_nxt;
    logic [CNT_WIDTH-1:0]    ar_cnt;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic [OUTST_WIDTH-1:0]  outst;
    logic                    type_q;
    logic                    abuf_id_q;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic                    beat_phase;
    logic                    cmd_hs;
    logic                    ar_hs;
    logic                    r_hs;

    assign beat_phase = (state == ISSUE) || (state == DRAIN);
    assign cmd_hs     = cmd_valid_i && cmd_ready_o;
    assign ar_hs      = ar_valid_o && ar_ready_i;
    assign r_hs       = r_valid_i && r_ready_o;

    assign cmd_ready_o = (state == IDLE);
    assign busy_o      = (state != IDLE);
    assign done_o      = (state == DONE);

    // Request side: credit-gated; address depends only on registered state, so it holds while stalled.
    assign ar_valid_o = (state == ISSUE) && (outst < OUTST_MAX);
    assign ar_addr_o  = base_q + (ADDR_WIDTH'(ar_cnt) << STRIDE_LOG2);

    // Return side: PRELOADA always sinks into the A-buffer, TMMA is back-pressured by the top feed.
    assign r_ready_o       = beat_phase && (type_q || top_ready_i);
    assign abuf_wr_valid_o = beat_phase && type_q && r_valid_i;
    assign abuf_wr_id_o    = abuf_id_q;
    assign abuf_wr_idx_o   = r_cnt;
    assign abuf_wr_data_o  = r_data_i;
    assign top_valid_o     = beat_phase && !type_q && r_valid_i;
    assign top_cnt_o       = r_cnt;
    assign top_data_o      = r_data_i;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid_i) state_nxt = ISSUE;
            ISSUE:   if (ar_hs && (ar_cnt == LAST_BEAT)) state_nxt = DRAIN;
            DRAIN:   if (r_hs && (r_cnt == LAST_BEAT)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_cnt    <= '0;
            r_cnt     <= '0;
            outst     <= '0;
            type_q    <= 1'b0;
            abuf_id_q <= 1'b0;
            base_q    <= '0;
        end else if (cmd_hs) begin
            ar_cnt    <= '0;
            r_cnt     <= '0;
            outst     <= '0;
            type_q    <= cmd_type_i;
            abuf_id_q <= cmd_abuf_id_i;
            base_q    <= cmd_addr_i;
        end else begin
            if (ar_hs) ar_cnt <= ar_cnt + 1'b1;
            if (r_hs)  r_cnt  <= r_cnt + 1'b1;
            // A stray beat with nothing outstanding leaves the credit count pinned at zero.
            if (ar_hs && !r_hs)                         outst <= outst + 1'b1;
            else if (r_hs && !ar_hs && (outst != '0))   outst <= outst - 1'b1;
        end
    end

endmodule

// File: tb/tb_sarray_ld_sched.sv
// Bench for sarray_ld_sched: vector table, directed corner sequences and randomized bursts
// checked every cycle against a transaction-level model with an in-order memory responder.
module tb_sarray_ld_sched;

    localparam int AW = 64;
    localparam int LW = 256;
    localparam int BEATS = 64;
    localparam int CW = 6;
    localparam int MO = 8;
    localparam logic [AW-1:0] STRIDE = 64'd256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          cmd_valid = 1'b0, cmd_type = 1'b0, cmd_abuf_id = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic          ar_ready = 1'b0, r_valid = 1'b0, top_ready = 1'b0;
    logic [LW-1:0] r_data = '0;
    logic          cmd_ready_o, ar_valid_o, r_ready_o, abuf_wr_valid_o, abuf_wr_id_o;
    logic          top_valid_o, busy_o, done_o;
    logic [AW-1:0] ar_addr_o;
    logic [CW-1:0] abuf_wr_idx_o, top_cnt_o;
    logic [LW-1:0] abuf_wr_data_o, top_data_o;

    sarray_ld_sched dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_type_i(cmd_type),
        .cmd_addr_i(cmd_addr), .cmd_abuf_id_i(cmd_abuf_id),
        .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready), .ar_addr_o(ar_addr_o),
        .r_valid_i(r_valid), .r_ready_o(r_ready_o), .r_data_i(r_data),
        .abuf_wr_valid_o(abuf_wr_valid_o), .abuf_wr_id_o(abuf_wr_id_o),
        .abuf_wr_idx_o(abuf_wr_idx_o), .abuf_wr_data_o(abuf_wr_data_o),
        .top_valid_o(top_valid_o), .top_ready_i(top_ready), .top_cnt_o(top_cnt_o),
        .top_data_o(top_data_o), .busy_o(busy_o), .done_o(done_o)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [LW-1:0] beat(input logic [AW-1:0] a);
        return {a ^ 64'hA5A5_5A5A_0F0F_F0F0, ~a, a + 64'd1, a};
    endfunction

    // Transaction-level model: a burst is "requests issued" and "beats received" counts.
    bit            m_active = 0, m_done = 0, m_type = 0, m_id = 0;
    logic [AW-1:0] m_base = '0;
    int            m_iss = 0, m_rcv = 0;
    int            cyc = 0, last_beat_cyc = 0;

    logic [AW-1:0] mq_addr[$];
    int            mq_due[$];
    bit            mem_on = 0, mem_rand = 0, cmd_noise = 0;
    int            lat_min = 3, lat_max = 3;
    int            ar_mode = 0, top_mode = 0;

    logic [6:0]    s_ctrl;
    logic [AW-1:0] s_addr;
    int            s_cyc;
    logic [AW-1:0] ar_log[$];
    int            top_log[$];
    int            n_abuf = 0, n_top = 0, n_done = 0;

    task automatic tick();
        bit            idle, e_arv, e_rr, ar_hs, r_hs;
        logic [6:0]    e_ctrl;
        logic [AW-1:0] e_addr, raddr;
        if (ar_mode == 1) ar_ready = 1'($urandom_range(0, 1));
        if (top_mode == 1) top_ready = 1'($urandom_range(0, 1));
        else if (top_mode == 2) top_ready = ~top_ready;
        if (mem_rand) mem_on = ($urandom_range(0, 3) != 0);
        if (cmd_noise) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_type  = 1'($urandom_range(0, 1));
            cmd_addr  = {$urandom, $urandom};
        end
        if (mem_on && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            r_valid = 1'b1;
            r_data  = beat(mq_addr[0]);
        end else begin
            r_valid = 1'b0;
            r_data  = '0;
        end
        #2;
        idle   = !m_active && !m_done;
        e_arv  = m_active && (m_iss < BEATS) && ((m_iss - m_rcv) < MO);
        e_rr   = m_active && (m_type || top_ready);
        e_addr = m_base + AW'(m_iss) * STRIDE;
        raddr  = m_base + AW'(m_rcv) * STRIDE;
        e_ctrl = {idle, e_arv, e_rr, m_active && m_type && r_valid,
                  m_active && !m_type && r_valid, !idle, m_done};
        s_ctrl = {cmd_ready_o, ar_valid_o, r_ready_o, abuf_wr_valid_o, top_valid_o, busy_o, done_o};
        s_addr = ar_addr_o;
        s_cyc  = cyc;
        chk("ctrl", LW'(s_ctrl), LW'(e_ctrl));
        if (e_arv && ar_valid_o) chk("ar_addr", LW'(ar_addr_o), LW'(e_addr));
        if (e_ctrl[3] && abuf_wr_valid_o) begin
            chk("abuf_idx", LW'(abuf_wr_idx_o), LW'(m_rcv % BEATS));
            chk("abuf_id", LW'(abuf_wr_id_o), LW'(m_id));
            chk("abuf_data", abuf_wr_data_o, beat(raddr));
        end
        if (e_ctrl[2] && top_valid_o) begin
            chk("top_cnt", LW'(top_cnt_o), LW'(m_rcv % BEATS));
            chk("top_data", top_data_o, beat(raddr));
        end
        if (ar_valid_o && ar_ready) ar_log.push_back(ar_addr_o);
        if (r_valid && r_ready_o && abuf_wr_valid_o) n_abuf++;
        if (r_valid && r_ready_o && top_valid_o) begin
            n_top++;
            top_log.push_back(int'(top_cnt_o));
        end
        if (done_o) n_done++;

        ar_hs = e_arv && ar_ready;
        r_hs  = r_valid && e_rr;
        if (idle && cmd_valid) begin
            m_active = 1; m_type = cmd_type; m_id = cmd_abuf_id; m_base = cmd_addr;
            m_iss = 0; m_rcv = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_active) begin
            if (ar_hs) begin
                mq_addr.push_back(e_addr);
                mq_due.push_back(cyc + $urandom_range(lat_max, lat_min));
                m_iss++;
            end
            if (r_hs) begin
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
                m_rcv++;
            end
            if (m_rcv == BEATS) begin
                m_active = 0; m_done = 1; last_beat_cyc = cyc;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_cmd(input bit t, input logic [AW-1:0] a, input bit id);
        cmd_valid = 1'b1; cmd_type = t; cmd_addr = a; cmd_abuf_id = id;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic run_until_done(input string name, input int budget);
        int n = 0;
        while (!m_done && n < budget) begin
            tick();
            n++;
        end
        if (!m_done) begin
            n_chk++;
            $display("FAIL %s_timeout: no completion after %0d cycles, beats %0d of %0d", name, budget, m_rcv, BEATS);
        end
    endtask

    typedef struct {
        bit         cv, ct, arr, mem, tr;
        logic [6:0] ctrl;
        logic [15:0] addr;
    } vec_t;
    vec_t vecs[18];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{0, 0, 1, 0, 1, 7'b1000000, 16'h0000};
        vecs[1]  = '{1, 0, 1, 0, 1, 7'b1000000, 16'h0000};
        vecs[2]  = '{0, 0, 1, 0, 1, 7'b0110010, 16'h2000};
        vecs[3]  = '{0, 0, 0, 0, 1, 7'b0110010, 16'h2100};
        vecs[4]  = '{0, 0, 0, 0, 0, 7'b0100010, 16'h2100};
        vecs[5]  = '{0, 0, 1, 0, 1, 7'b0110010, 16'h2100};
        vecs[6]  = '{1, 1, 1, 0, 1, 7'b0110010, 16'h2200};
        vecs[7]  = '{0, 0, 1, 0, 1, 7'b0110010, 16'h2300};
        vecs[8]  = '{0, 0, 1, 0, 1, 7'b0110010, 16'h2400};
        vecs[9]  = '{0, 0, 1, 0, 1, 7'b0110010, 16'h2500};
        vecs[10] = '{0, 0, 1, 0, 1, 7'b0110010, 16'h2600};
        vecs[11] = '{0, 0, 1, 0, 1, 7'b0110010, 16'h2700};
        vecs[12] = '{0, 0, 1, 0, 1, 7'b0010010, 16'h0000};
        vecs[13] = '{0, 0, 1, 0, 1, 7'b0010010, 16'h0000};
        vecs[14] = '{0, 0, 1, 1, 1, 7'b0010110, 16'h0000};
        vecs[15] = '{0, 0, 0, 0, 1, 7'b0110010, 16'h2800};
        vecs[16] = '{0, 0, 1, 0, 1, 7'b0110010, 16'h2800};
        vecs[17] = '{0, 0, 1, 0, 1, 7'b0010010, 16'h0000};

        // Reset state
        #12;
        chk("reset_ctrl", LW'({cmd_ready_o, ar_valid_o, r_ready_o, abuf_wr_valid_o, top_valid_o, busy_o, done_o}),
            LW'(7'b1000000));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Vector table: TMMA at 0x2000 against a stalled memory, credit limit, one-beat release
        cmd_addr = 64'h2000; cmd_abuf_id = 1'b0;
        for (int i = 0; i < 18; i++) begin
            cmd_valid = vecs[i].cv; cmd_type = vecs[i].ct; ar_ready = vecs[i].arr;
            mem_on = vecs[i].mem; top_ready = vecs[i].tr;
            tick();
            chk($sformatf("vec%0d_ctrl", i), LW'(s_ctrl), LW'(vecs[i].ctrl));
            if (vecs[i].ctrl[5]) chk($sformatf("vec%0d_addr", i), LW'(s_addr[15:0]), LW'(vecs[i].addr));
        end
        cmd_valid = 1'b0; cmd_type = 1'b0;
        mem_on = 1; ar_mode = 1; top_mode = 1;
        run_until_done("table_tail", 3000);
        tick();

        // PRELOADA at 0x1000, bank 1, always-ready requests, fixed 3-cycle memory
        ar_mode = 0; ar_ready = 1'b1; top_mode = 1; lat_min = 3; lat_max = 3; mem_on = 1;
        ar_log.delete(); n_abuf = 0; n_done = 0;
        start_cmd(1'b1, 64'h1000, 1'b1);
        run_until_done("preload", 2000);
        tick();
        chk("preload_done_cycle_ready", LW'(s_ctrl[6]), LW'(1'b0));
        tick();
        chk("preload_ready_back", LW'(s_ctrl[6]), LW'(1'b1));
        chk("preload_ready_delay", LW'(s_cyc - last_beat_cyc), LW'(2));
        chk("preload_req_count", LW'(ar_log.size()), LW'(64));
        if (ar_log.size() == 64) begin
            chk("preload_addr1", LW'(ar_log[1]), LW'(64'h1100));
            chk("preload_addr63", LW'(ar_log[63]), LW'(64'h4F00));
        end
        chk("preload_abuf_writes", LW'(n_abuf), LW'(64));
        chk("preload_done_pulses", LW'(n_done), LW'(1));

        // TMMA with top_ready toggling
        top_mode = 2; top_ready = 1'b0; n_top = 0; top_log.delete();
        start_cmd(1'b0, 64'h0, 1'b0);
        run_until_done("toggle", 3000);
        tick();
        chk("toggle_top_beats", LW'(n_top), LW'(64));
        begin
            int bad = 0;
            foreach (top_log[i]) if (top_log[i] != i) bad++;
            chk("toggle_top_cnt_seq_errors", LW'(bad), LW'(0));
        end

        // Address wrap past 2^64
        top_mode = 1; ar_mode = 1; lat_min = 1; lat_max = 4; ar_log.delete();
        start_cmd(1'b1, 64'hFFFF_FFFF_FFFF_F000, 1'b0);
        run_until_done("wrap", 3000);
        tick();
        chk("wrap_req_count", LW'(ar_log.size()), LW'(64));
        if (ar_log.size() == 64) begin
            chk("wrap_addr15", LW'(ar_log[15]), LW'(64'hFFFF_FFFF_FFFF_FF00));
            chk("wrap_addr16", LW'(ar_log[16]), LW'(64'h0));
        end

        // Simultaneous request and beat handshakes at the credit edge, then a command during DONE
        ar_mode = 0; ar_ready = 1'b1; top_mode = 0; top_ready = 1'b1; mem_on = 0; lat_min = 1; lat_max = 1;
        start_cmd(1'b0, 64'h3000, 1'b0);
        for (int n = 0; n < 20 && m_iss < 7; n++) tick();
        mem_on = 1;
        tick();
        chk("simul_both_arv", LW'(s_ctrl[5]), LW'(1'b1));
        chk("simul_both_topv", LW'(s_ctrl[2]), LW'(1'b1));
        mem_on = 0;
        tick();
        chk("simul_after_arv", LW'(s_ctrl[5]), LW'(1'b1));
        tick();
        chk("simul_full_arv", LW'(s_ctrl[5]), LW'(1'b0));
        mem_on = 1; ar_mode = 1;
        run_until_done("simul", 3000);
        cmd_valid = 1'b1; cmd_type = 1'b1; cmd_addr = 64'h5000; cmd_abuf_id = 1'b0;
        tick();
        chk("done_cmd_blocked", LW'(s_ctrl[6]), LW'(1'b0));
        chk("done_pulse", LW'(s_ctrl[0]), LW'(1'b1));
        tick();
        chk("idle_cmd_accepted", LW'(s_ctrl[6]), LW'(1'b1));
        cmd_valid = 1'b0;
        run_until_done("after_done_cmd", 3000);
        tick();

        // Reset in the middle of a burst
        ar_mode = 0; ar_ready = 1'b1; mem_on = 1; lat_min = 3; lat_max = 3;
        start_cmd(1'b1, 64'h6000, 1'b1);
        for (int n = 0; n < 60 && m_iss < 20; n++) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_ctrl", LW'({cmd_ready_o, ar_valid_o, r_ready_o, abuf_wr_valid_o, top_valid_o, busy_o, done_o}),
            LW'(7'b1000000));
        m_active = 0; m_done = 0;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        tick();
        chk("post_rst_r_valid_seen", LW'(r_valid), LW'(1'b1));
        chk("post_rst_r_ready", LW'(s_ctrl[4]), LW'(1'b0));
        tick();
        mq_addr.delete(); mq_due.delete(); ar_log.delete();
        start_cmd(1'b0, 64'h7000, 1'b0);
        run_until_done("post_rst", 2000);
        tick();
        if (ar_log.size() > 0) chk("post_rst_first_addr", LW'(ar_log[0]), LW'(64'h7000));
        else chk("post_rst_req_count", LW'(ar_log.size()), LW'(64));

        // Randomized bursts with noisy command inputs and random back-pressure
        ar_mode = 1; top_mode = 1; lat_min = 1; lat_max = 6; mem_rand = 1;
        for (int k = 0; k < 4; k++) begin
            start_cmd(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
            cmd_noise = 1;
            run_until_done($sformatf("rand%0d", k), 3000);
            cmd_noise = 0; cmd_valid = 1'b0;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
